vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised raster timing generator for the flame demo's video path. It replaces fixed 640x480 hard-coded counters with generic H/V timing, selectable sync polarity and an integrated pixel clock-enable divider. It also adds frame counting and a synchronous resync (genlock) input. It drives the pixel-generation logic and the hsync/vsync pins on uo_out.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, active level of hsync (0 = active-low)
V_SYNC_POL, 0, active level of vsync
CLK_DIV, 1, clk cycles per pixel (>=1)
FRAME_CNT_W, 8, width of frame counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
ena  in  1  advance enable; low freezes divider and counters
resync  in  1  synchronous restart of raster to (0,0)
pix_ce  out  1  pixel clock-enable strobe
hpos  out  HW  current column, HW = clog2(H_TOTAL)
vpos  out  VW  current line, VW = clog2(V_TOTAL)
hsync  out  1  horizontal sync, polarity per H_SYNC_POL
vsync  out  1  vertical sync, polarity per V_SYNC_POL
display_on  out  1  high when hpos<H_ACTIVE and vpos<V_ACTIVE
line_start  out  1  one-clk strobe: pix_ce high and hpos==0
frame_start  out  1  one-clk strobe: pix_ce high and hpos==0 and vpos==0
frame_cnt  out  FRAME_CNT_W  frames completed, wraps modulo 2^FRAME_CNT_W

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Divider: counter div in 0..CLK_DIV-1, increments each clk while ena=1. pix_ce = ena & (div==CLK_DIV-1). CLK_DIV=1 gives pix_ce = ena.
- Raster: on pix_ce, hpos increments.
  - hpos==H_TOTAL-1: hpos->0 and vpos increments.
  - vpos==V_TOTAL-1 at line end: vpos->0 and frame_cnt+1.
- hsync active iff H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC; vsync likewise on vpos.
- hsync, vsync and display_on are registered and updated in the same clk edge as hpos/vpos from the next-state values, so they are always aligned with hpos/vpos (zero relative latency).
- line_start and frame_start are combinational from pix_ce and the registered counters. They mark the first pixel of the current position.
- resync=1 at a clk edge: div, hpos and vpos go to 0. frame_cnt holds. Outputs take their (0,0) decode. resync overrides ena and overrides a simultaneous wrap, so frame_cnt does not increment.
- ena=0: all state holds, pix_ce=0, strobes 0. resync still acts.
- Reset values: div=0, hpos=0, vpos=0, frame_cnt=0, display_on=1, hsync=~H_SYNC_POL, vsync=~V_SYNC_POL. pix_ce=0 during reset.
- Reset mid-frame acts immediately and asynchronously. The first pixel after release is (0,0).
- frame_cnt wraps from 2^FRAME_CNT_W-1 to 0 silently.
- Elaboration check: reject CLK_DIV<1 or any timing parameter of 0.

Decomposition:
- Package vga_timing_pkg: timing-parameter struct typedef, clog2-based width helper, and constants for the 640x480@60 defaults.
- One sub-module, tick_div: generic clock-enable divider with ena, clear and strobe outputs. It is instantiated for pix_ce.
- H/V counters and decode stay in the top.

Test Plan:
Small params for all tests: H 8/2/3/1 (H_TOTAL=14), V 4/1/1/1 (V_TOTAL=7), CLK_DIV=2, FRAME_CNT_W=2.
- Reset release, ena=1 -> pix_ce on every 2nd clk. hpos steps 0..13 then 0 with vpos=1. hsync low exactly for hpos 10..12. display_on low for hpos>=8.
- Run 98 pix_ce -> vpos returns to 0. vsync low only on vpos=5. frame_start pulses once per 98 pix_ce. frame_cnt counts 1,2,3,0 over 4 frames.
- Drop ena for 10 clks mid-line at hpos=5 -> hpos, div and frame_cnt frozen, no strobes. Resume -> continues from hpos=5 with the correct divider phase.
- Assert resync at hpos=13, vpos=6 on a pix_ce clk -> next hpos=0, vpos=0, frame_cnt unchanged. frame_start is seen on the next pix_ce.
- Assert rst asynchronously (between clk edges) at hpos=9, vpos=2 -> outputs reach reset values without a clk edge: hsync=1, display_on=1, frame_cnt=0.
- Re-elaborate with H_SYNC_POL=1, CLK_DIV=1 -> pix_ce constantly high with ena. hsync high for hpos 10..12, low elsewhere.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing types, width helper and 640x480@60 default constants for the
// raster timing generator.
package vga_timing_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } axis_timing_t;

    localparam axis_timing_t VGA640_H = '{active: 640, fp: 16, sync: 96, bp: 48};
    localparam axis_timing_t VGA480_V = '{active: 480, fp: 10, sync: 2, bp: 33};

    function automatic int axis_total(axis_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    function automatic int sync_start(axis_timing_t t);
        return t.active + t.fp;
    endfunction

    function automatic int sync_end(axis_timing_t t);
        return t.active + t.fp + t.sync;
    endfunction

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit axis_valid(axis_timing_t t);
        return (t.active > 0) && (t.fp > 0) && (t.sync > 0) && (t.bp > 0);
    endfunction

endpackage

// File: rtl/vga_timing_gen_tick_div.sv
// Generic clock-enable divider: strobes once every DIV enabled clocks.
module tick_div
    import vga_timing_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic ena_i,
    input  logic clear_i,
    output logic strobe_o
);

    localparam int DW = cnt_width(DIV);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    if (DIV < 1) begin : g_bad_div
        $error("tick_div: DIV must be at least 1");
    end

    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    // Next divider phase: clear wins over enable, wrap at DIV-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (ena_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Divider phase register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Gated by rst so a DIV=1 divider cannot strobe while held in reset.
    assign strobe_o = ena_i & ~rst & (cnt_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel clock-enable, H/V counters,
// sync/blanking decode, line/frame strobes, frame counter and resync.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = VGA640_H.active,
    parameter int H_FP        = VGA640_H.fp,
    parameter int H_SYNC      = VGA640_H.sync,
    parameter int H_BP        = VGA640_H.bp,
    parameter int V_ACTIVE    = VGA480_V.active,
    parameter int V_FP        = VGA480_V.fp,
    parameter int V_SYNC      = VGA480_V.sync,
    parameter int V_BP        = VGA480_V.bp,
    parameter bit H_SYNC_POL  = 1'b0,
    parameter bit V_SYNC_POL  = 1'b0,
    parameter int CLK_DIV     = 1,
    parameter int FRAME_CNT_W = 8,
    localparam int HW = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int VW = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   resync,
    output logic                   pix_ce,
    output logic [HW-1:0]          hpos,
    output logic [VW-1:0]          vpos,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   display_on,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam axis_timing_t H_CFG = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam axis_timing_t V_CFG = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};

    localparam int H_TOTAL = axis_total(H_CFG);
    localparam int V_TOTAL = axis_total(V_CFG);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_START_C = HW'(sync_start(H_CFG));
    localparam logic [HW-1:0] HS_END_C   = HW'(sync_end(H_CFG));
    localparam logic [VW-1:0] VS_START_C = VW'(sync_start(V_CFG));
    localparam logic [VW-1:0] VS_END_C   = VW'(sync_end(V_CFG));

    if (CLK_DIV < 1 || !axis_valid(H_CFG) || !axis_valid(V_CFG) || FRAME_CNT_W < 1) begin : g_bad_params
        $error("vga_timing_gen: CLK_DIV and all timing parameters must be non-zero");
    end

    logic [HW-1:0]          hpos_q, hpos_d;
    logic [VW-1:0]          vpos_q, vpos_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   hsync_q, hsync_d;
    logic                   vsync_q, vsync_d;
    logic                   display_on_q, display_on_d;

    tick_div #(
        .DIV (CLK_DIV)
    ) u_pix_div (
        .clk      (clk),
        .rst      (rst),
        .ena_i    (ena),
        .clear_i  (resync),
        .strobe_o (pix_ce)
    );

    // Raster advance plus decode of the next position, so sync and blanking
    // registers land on the same edge as the counters they describe.
    always_comb begin
        hpos_d      = hpos_q;
        vpos_d      = vpos_q;
        frame_cnt_d = frame_cnt_q;

        if (resync) begin
            hpos_d = '0;
            vpos_d = '0;
        end else if (pix_ce) begin
            if (hpos_q == H_LAST) begin
                hpos_d = '0;
                if (vpos_q == V_LAST) begin
                    vpos_d      = '0;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end else begin
                    vpos_d = vpos_q + 1'b1;
                end
            end else begin
                hpos_d = hpos_q + 1'b1;
            end
        end

        hsync_d      = ((hpos_d >= HS_START_C) && (hpos_d < HS_END_C)) ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_d      = ((vpos_d >= VS_START_C) && (vpos_d < VS_END_C)) ? V_SYNC_POL : ~V_SYNC_POL;
        display_on_d = (hpos_d < H_ACT_END) && (vpos_d < V_ACT_END);
    end

    // Counter and decoded-output registers; reset leaves the raster at (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hpos_q       <= '0;
            vpos_q       <= '0;
            frame_cnt_q  <= '0;
            hsync_q      <= ~H_SYNC_POL;
            vsync_q      <= ~V_SYNC_POL;
            display_on_q <= 1'b1;
        end else begin
            hpos_q       <= hpos_d;
            vpos_q       <= vpos_d;
            frame_cnt_q  <= frame_cnt_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            display_on_q <= display_on_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign frame_cnt   = frame_cnt_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = display_on_q;
    assign line_start  = pix_ce & (hpos_q == '0);
    assign frame_start = line_start & (vpos_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: two generator instances (CLK_DIV=2 active-low hsync and
// CLK_DIV=1 active-high hsync) against a linear pixel-index reference model.
module tb_vga_timing_gen;

    localparam int HT      = 8 + 2 + 3 + 1;
    localparam int VT      = 4 + 1 + 1 + 1;
    localparam int FRAME_N = HT * VT;

    typedef struct packed {
        logic [3:0] h;
        logic [2:0] v;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic [1:0] fc;
    } exp_t;

    logic clk, rst, ena, resync;

    logic       pix_a, hs_a, vs_a, de_a, ls_a, fs_a;
    logic [3:0] hpos_a;
    logic [2:0] vpos_a;
    logic [1:0] fc_a;

    logic       pix_b, hs_b, vs_b, de_b, ls_b, fs_b;
    logic [3:0] hpos_b;
    logic [2:0] vpos_b;
    logic [1:0] fc_b;

    int total = 0;
    int bad   = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    int pos[2];
    int frames[2];
    int cnt_en[2];
    int div_of[2] = '{2, 1};
    bit hpol[2]   = '{1'b0, 1'b1};

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
        .CLK_DIV(2), .FRAME_CNT_W(2)
    ) dut_a (
        .clk(clk), .rst(rst), .ena(ena), .resync(resync),
        .pix_ce(pix_a), .hpos(hpos_a), .vpos(vpos_a),
        .hsync(hs_a), .vsync(vs_a), .display_on(de_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0),
        .CLK_DIV(1), .FRAME_CNT_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .ena(ena), .resync(resync),
        .pix_ce(pix_b), .hpos(hpos_b), .vpos(vpos_b),
        .hsync(hs_b), .vsync(vs_b), .display_on(de_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
        end
    endtask

    // Expected outputs for a pixel given its index within the frame.
    function automatic exp_t predict(input int p, input int f, input bit pol);
        exp_t e;
        int   h, v;
        bit   hact;
        h    = p % HT;
        v    = p / HT;
        hact = (h >= 10) && (h <= 12);
        e.h  = 4'(h);
        e.v  = 3'(v);
        e.hs = pol ? hact : !hact;
        e.vs = !(v == 5);
        e.de = (h < 8) && (v < 4);
        e.ls = (h == 0);
        e.fs = (p == 0);
        e.fc = 2'(f % 4);
        return e;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            pos[d]    = 0;
            frames[d] = 0;
            cnt_en[d] = 0;
        end
    endtask

    // One clock of stimulus: drive inputs, queue expectations, advance model.
    task automatic step(input bit e, input bit r);
        bit pix;
        #1;
        ena    = e;
        resync = r;
        for (int d = 0; d < 2; d++) begin
            pix = e && (((cnt_en[d] + 1) % div_of[d]) == 0);
            if (pix) begin
                if (d == 0) qa.push_back(predict(pos[d], frames[d], hpol[d]));
                else        qb.push_back(predict(pos[d], frames[d], hpol[d]));
            end
            if (r) begin
                pos[d]    = 0;
                cnt_en[d] = 0;
            end else if (e) begin
                cnt_en[d]++;
                if (pix) begin
                    pos[d]++;
                    if (pos[d] == FRAME_N) begin
                        pos[d] = 0;
                        frames[d]++;
                    end
                end
            end
        end
        @(posedge clk);
    endtask

    // Monitor for the CLK_DIV=2 instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (pix_a) begin
                if (qa.size() == 0) begin
                    chk("A_unexpected_pix_ce", 1, 0);
                end else begin
                    ea = qa.pop_front();
                    chk("A_hpos", hpos_a, ea.h);
                    chk("A_vpos", vpos_a, ea.v);
                    chk("A_hsync", hs_a, ea.hs);
                    chk("A_vsync", vs_a, ea.vs);
                    chk("A_display_on", de_a, ea.de);
                    chk("A_line_start", ls_a, ea.ls);
                    chk("A_frame_start", fs_a, ea.fs);
                    chk("A_frame_cnt", fc_a, ea.fc);
                end
            end else begin
                chk("A_idle_line_start", ls_a, 0);
                chk("A_idle_frame_start", fs_a, 0);
            end
        end
    end

    // Monitor for the CLK_DIV=1 active-high-hsync instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (pix_b) begin
                if (qb.size() == 0) begin
                    chk("B_unexpected_pix_ce", 1, 0);
                end else begin
                    eb = qb.pop_front();
                    chk("B_hpos", hpos_b, eb.h);
                    chk("B_vpos", vpos_b, eb.v);
                    chk("B_hsync", hs_b, eb.hs);
                    chk("B_vsync", vs_b, eb.vs);
                    chk("B_display_on", de_b, eb.de);
                    chk("B_line_start", ls_b, eb.ls);
                    chk("B_frame_start", fs_b, eb.fs);
                    chk("B_frame_cnt", fc_b, eb.fc);
                end
            end else begin
                chk("B_idle_line_start", ls_b, 0);
                chk("B_idle_frame_start", fs_b, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        ena    = 1'b1;
        resync = 1'b0;
        model_reset();
        #12;
        chk("rst_pix_ce_a", pix_a, 0);
        chk("rst_pix_ce_b", pix_b, 0);
        chk("rst_hpos", hpos_a, 0);
        chk("rst_vpos", vpos_a, 0);
        chk("rst_hsync_a", hs_a, 1);
        chk("rst_hsync_b", hs_b, 0);
        chk("rst_vsync", vs_a, 1);
        chk("rst_display_on", de_a, 1);
        chk("rst_frame_cnt", fc_a, 0);
        @(posedge clk);
        #1;
        ena = 1'b0;
        rst = 1'b0;
        @(posedge clk);

        // Free run across several frames so frame_cnt wraps.
        for (int k = 0; k < 900; k++) step(1'b1, 1'b0);

        // Freeze mid-line at hpos=5.
        for (int k = 0; k < 400 && (pos[0] % HT) != 5; k++) step(1'b1, 1'b0);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0);
        #2;
        chk("freeze_hpos", hpos_a, 5);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0);

        // Resync on the last pixel of the frame (hpos=13, vpos=6) on a pix_ce clock.
        for (int k = 0; k < 800 && !(pos[0] == FRAME_N - 1 && (cnt_en[0] % 2) == 1); k++)
            step(1'b1, 1'b0);
        #2;
        chk("pre_resync_hpos", hpos_a, 13);
        chk("pre_resync_vpos", vpos_a, 6);
        step(1'b1, 1'b1);
        #2;
        chk("resync_hpos", hpos_a, 0);
        chk("resync_vpos", vpos_a, 0);
        chk("resync_frame_cnt", fc_a, frames[0] % 4);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0);

        // Randomised enable/resync traffic.
        for (int k = 0; k < 2000; k++)
            step(($urandom % 4) != 0, ($urandom % 150) == 0);

        // Asynchronous reset between edges at hpos=9, vpos=2.
        for (int k = 0; k < 800 && pos[0] != 2 * HT + 9; k++) step(1'b1, 1'b0);
        #2;
        chk("pre_rst_hpos", hpos_a, 9);
        chk("pre_rst_vpos", vpos_a, 2);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_hpos", hpos_a, 0);
        chk("arst_vpos", vpos_a, 0);
        chk("arst_hsync", hs_a, 1);
        chk("arst_display_on", de_a, 1);
        chk("arst_frame_cnt", fc_a, 0);
        chk("arst_pix_ce_b", pix_b, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        ena = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 300; k++) step(1'b1, 1'b0);

        ena = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("queue_a_drained", qa.size(), 0);
        chk("queue_b_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
